mc_mem_responder: RTL and testbench
===================================

# mc_mem_responder

Memory-side responder for the multicycle MIPS core: the far end of the control unit's memory requests (instruction fetch, load, store). It accepts one request at a time over a valid/ready handshake. It inserts a fixed number of wait states, then returns one single-cycle response carrying read data or a write acknowledge. It holds unified instruction/data storage and flags misaligned or out-of-range accesses.

## Interface
- ADDR_W, 8, word-address width; storage depth is 2**ADDR_W 32-bit words
- WAIT_CYC, 2, wait states between acceptance and response (0..15)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_write  in  1  1 = store, 0 = load/fetch
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; present only with MEM_BYTE_EN_EN
- req_ready  out  1  responder can accept; reset 1
- rsp_valid  out  1  response strobe, exactly one cycle; reset 0
- rsp_rdata  out  32  read data, held until the next response; reset 0
- rsp_err  out  1  access error, qualified by rsp_valid; reset 0

## Operation
- States: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE: req_ready=1. When req_valid=1, the request is accepted at the clock edge. The responder registers addr, wdata, write, and be, and loads the wait counter with WAIT_CYC.
  - WAIT_CYC>0: go to WAIT.
  - WAIT_CYC=0: go to RESP.
- WAIT: req_ready=0. The counter decrements each cycle. When it reaches 1, go to RESP on the next edge.
- RESP: rsp_valid=1 for one cycle and req_ready=0. Then return to IDLE.
- Error conditions:
  - addr[1:0]≠0 (misaligned), or
  - addr[31:ADDR_W+2]≠0 (out of range).
- On error: rsp_err=1, rsp_rdata=0, and no storage write.
- Read: rsp_rdata = word at addr[ADDR_W+1:2], sampled on the edge entering RESP.
- Write: the storage update commits on the edge entering RESP. rsp_rdata=0 for write responses. The new data is visible to any later request.
- While not in IDLE, req_valid and the request fields are ignored.
- Storage is not cleared by reset. Contents are undefined until written.

## Timing
- Acceptance at edge E0. rsp_valid is high in cycle E0+1+WAIT_CYC.
- req_ready is high again in the cycle after rsp_valid. Minimum request period is WAIT_CYC+2 cycles.
- Back-to-back: a request held valid across RESP is accepted on the first IDLE edge.
- Reset asserted mid-operation: immediately IDLE, rsp_valid=0, req_ready=1. A pending write that has not yet reached its RESP edge is discarded. rsp_rdata and rsp_err are cleared to 0.
- Wait counter is 4 bits wide. WAIT_CYC>15 is illegal and is caught by an elaboration check.

## Configuration
- MEM_BYTE_EN_EN defined:
  - req_be port exists. A write updates only the bytes whose req_be bit is 1; req_be[0] covers bits 7:0.
  - req_be=0 acknowledges without changing storage.
  - Misalignment check is unchanged (word aligned).
- Not defined: no req_be port. Every write updates the full 32-bit word.

## Structure
- Package mc_mem_pkg:
  - state enum (IDLE/WAIT/RESP)
  - WORD_BYTES=4
  - BE_FULL=4'hF
  - error-check function for address range and alignment
- Sub-module mc_mem_array: synchronous word array with per-byte write enables. BE is tied to BE_FULL when MEM_BYTE_EN_EN is absent. The FSM, counter, and response registers stay in mc_mem_responder.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10, then read 0x10 (WAIT_CYC=2) -> each rsp_valid arrives 3 cycles after acceptance; the read returns 0xDEADBEEF with rsp_err=0.
- Read 0x0000_0402 -> rsp_err=1, rsp_rdata=0. A subsequent read of 0x400 (out of range for ADDR_W=8) -> rsp_err=1.
- WAIT_CYC=0 with req_valid held high continuously -> one response every 2 cycles; req_ready toggles 1,0.
- With MEM_BYTE_EN_EN:
  - write 0x11223344 to 0x20 with be=4'hF
  - then write 0xAABBCCDD to 0x20 with be=4'b0101
  - read 0x20 -> 0x11BB33DD.
- Write 0xCAFEF00D to 0x8, then pulse rst_n low during WAIT -> the next read of 0x8 returns the old contents; outputs are 0 and req_ready=1 immediately after reset.
- A request field changes while in WAIT -> the response reflects the originally latched address and data.

Source files
------------

// File: rtl/mc_mem_pkg.sv
// mc_mem_pkg: shared state type, constants and access check for the memory responder
package mc_mem_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
   localparam int WORD_BYTES = 4;
   localparam logic [3:0] BE_FULL = 4'hF;
   // Misaligned word or any address bit above the storage window flags an error
   function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
      return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
   endfunction
endpackage

// File: rtl/mc_mem_array.sv
// mc_mem_array: unified word storage, combinational read and per-byte synchronous write
module mc_mem_array import mc_mem_pkg::*; #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   logic [31:0] mem_q [2**ADDR_W];
   always_ff @(posedge clk)
      for (int i = 0; i < WORD_BYTES; i++)
         if (we && be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
   assign rdata = mem_q[addr];
endmodule

// File: rtl/mc_mem_responder.sv
// mc_mem_responder: one-outstanding memory responder with WAIT_CYC wait states.
// Define MEM_BYTE_EN_EN to add the req_be port and byte-masked stores.
module mc_mem_responder import mc_mem_pkg::*; #(
   parameter int ADDR_W   = 8,
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef MEM_BYTE_EN_EN
   input  logic [3:0]  req_be,
`endif
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam logic [3:0] WAIT_L = 4'(WAIT_CYC);
   if (WAIT_CYC < 0 || WAIT_CYC > 15) begin : g_bad_wait
      $error("mc_mem_responder: WAIT_CYC must be in 0..15");
   end
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d, be_q, be_d, be_in, cur_be;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, cur_addr, cur_wdata;
   logic [31:0] rsp_rdata_q, rsp_rdata_d, mem_rdata;
   logic        write_q, write_d, rsp_err_q, rsp_err_d;
   logic        accept, to_resp, cur_write, cur_err, mem_we;
`ifdef MEM_BYTE_EN_EN
   assign be_in = req_be;
`else
   assign be_in = BE_FULL;
`endif
   // With WAIT_CYC=0 the RESP edge is the accept edge, so use the live request then
   assign accept    = (state_q == ST_IDLE) && req_valid;
   assign to_resp   = accept ? (WAIT_L == 4'd0) : (state_q == ST_WAIT) && (cnt_q == 4'd1);
   assign cur_addr  = accept ? req_addr : addr_q;
   assign cur_wdata = accept ? req_wdata : wdata_q;
   assign cur_write = accept ? req_write : write_q;
   assign cur_be    = accept ? be_in : be_q;
   assign cur_err   = addr_err(cur_addr, ADDR_W);
   assign mem_we    = to_resp && cur_write && !cur_err;
   always_comb begin
      state_d = to_resp ? ST_RESP : accept ? ST_WAIT : (state_q == ST_RESP) ? ST_IDLE : state_q;
      cnt_d   = accept ? WAIT_L : (state_q == ST_WAIT) ? cnt_q - 4'd1 : cnt_q;
      addr_d  = cur_addr;
      wdata_d = cur_wdata;
      write_d = cur_write;
      be_d    = cur_be;
   end
   always_comb begin
      rsp_rdata_d = to_resp ? ((cur_err || cur_write) ? 32'd0 : mem_rdata) : rsp_rdata_q;
      rsp_err_d   = to_resp ? cur_err : rsp_err_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         write_q     <= 1'b0;
         be_q        <= 4'd0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_q     <= write_d;
         be_q        <= be_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   mc_mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .be    (cur_be),
      .addr  (cur_addr[ADDR_W+1:2]),
      .wdata (cur_wdata),
      .rdata (mem_rdata)
   );
   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mc_mem_responder.sv
// tb_mc_mem_responder: directed checks of a WAIT_CYC=2 responder and a WAIT_CYC=0 responder
module tb_mc_mem_responder;
   logic clk = 1'b0, rst_n = 1'b1;
   logic req_valid = 1'b0, req_write = 1'b0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic v0 = 1'b0, w0 = 1'b0;
   logic [31:0] a0 = 32'd0, d0 = 32'd0;
   logic rdy0, vld0, err0;
   logic [31:0] rd0;
`ifdef MEM_BYTE_EN_EN
   logic [3:0] req_be = 4'hF, be0 = 4'hF;
`endif
   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   mc_mem_responder #(.ADDR_W(8), .WAIT_CYC(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_BYTE_EN_EN
      .req_be(req_be),
`endif
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   mc_mem_responder #(.ADDR_W(8), .WAIT_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_write(w0),
      .req_addr(a0), .req_wdata(d0),
`ifdef MEM_BYTE_EN_EN
      .req_be(be0),
`endif
      .req_ready(rdy0), .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(err0)
   );

   // One request on the WAIT_CYC=2 port; fields are scrambled once accepted
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = ~w; req_addr = a ^ 32'h4; req_wdata = ~d;
      lat = 0; rd = 'x; er = 1'bx;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(negedge clk);
         if (rsp_valid) begin lat = i; rd = rsp_rdata; er = rsp_err; end
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b need 1", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b need 0", rsp_valid); end
      n_cmp++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h need 0", rsp_rdata); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b need 0", rsp_err); end
      n_cmp++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL rst_ready0: got %b need 1", rdy0); end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL wr_lat: got %0d need 3", lat); end
      n_cmp++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL wr_rsp: got err=%b rdata=%h need 0/0", er, rd); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_after: got valid=%b ready=%b need 0/1", rsp_valid, req_ready); end
      xact(1'b0, 32'h10, 32'd0, rd, er, lat);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rd_lat: got %0d need 3", lat); end
      n_cmp++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp: got err=%b rdata=%h need 0/deadbeef", er, rd); end
      @(negedge clk);
      n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold: got %h need deadbeef", rsp_rdata); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic er; int lat;
      xact(1'b0, 32'h402, 32'd0, rd, er, lat);
      n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_mis: got err=%b rdata=%h need 1/0", er, rd); end
      xact(1'b0, 32'h400, 32'd0, rd, er, lat);
      n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL err_range: got err=%b rdata=%h need 1/0", er, rd); end
      xact(1'b1, 32'h410, 32'hFFFFFFFF, rd, er, lat);
      n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_wr: got err=%b need 1", er); end
      xact(1'b0, 32'h10, 32'd0, rd, er, lat);
      n_cmp++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_nowrite: got err=%b rdata=%h need 0/deadbeef", er, rd); end
      xact(1'b1, 32'h3FC, 32'h12345678, rd, er, lat);
      xact(1'b0, 32'h3FC, 32'd0, rd, er, lat);
      n_cmp++; if (er !== 1'b0 || rd !== 32'h12345678) begin n_fail++; $display("FAIL top_word: got err=%b rdata=%h need 0/12345678", er, rd); end
   endtask

   task automatic test_field_change();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 32'h14, 32'h600DCAFE, rd, er, lat);
      xact(1'b0, 32'h14, 32'd0, rd, er, lat);
      n_cmp++; if (rd !== 32'h600DCAFE) begin n_fail++; $display("FAIL latch_new: got %h need 600dcafe", rd); end
      xact(1'b0, 32'h10, 32'd0, rd, er, lat);
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL latch_old: got %h need deadbeef", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat;
      xact(1'b1, 32'h8, 32'h01020304, rd, er, lat);
      xact(1'b0, 32'h8, 32'd0, rd, er, lat);
      n_cmp++; if (rd !== 32'h01020304) begin n_fail++; $display("FAIL mid_pre: got %h need 01020304", rd); end
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ctrl: got valid=%b ready=%b need 0/1", rsp_valid, req_ready); end
      n_cmp++; if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL mid_data: got rdata=%h err=%b need 0/0", rsp_rdata, rsp_err); end
      @(negedge clk);
      rst_n = 1'b1;
      xact(1'b0, 32'h8, 32'd0, rd, er, lat);
      n_cmp++; if (rd !== 32'h01020304 || er !== 1'b0) begin n_fail++; $display("FAIL mid_post: got %h err=%b need 01020304/0", rd, er); end
   endtask

   task automatic test_back_to_back();
      logic e;
      int n_rsp = 0;
      @(negedge clk);
      v0 = 1'b1; w0 = 1'b1; a0 = 32'h0; d0 = 32'h0BADF00D;
      for (int i = 0; i < 6; i++) begin
         e = (i % 2 == 0);
         n_cmp++; if (rdy0 !== e || vld0 !== ~e) begin n_fail++; $display("FAIL b2b_%0d: got ready=%b valid=%b need %b/%b", i, rdy0, vld0, e, ~e); end
         if (vld0) n_rsp++;
         @(negedge clk);
      end
      n_cmp++; if (n_rsp !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d need 3", n_rsp); end
      w0 = 1'b0;
      @(posedge clk); #1;
      v0 = 1'b0;
      @(negedge clk);
      n_cmp++; if (vld0 !== 1'b1 || rd0 !== 32'h0BADF00D || err0 !== 1'b0) begin n_fail++; $display("FAIL w0_read: got valid=%b rdata=%h err=%b need 1/0badf00d/0", vld0, rd0, err0); end
   endtask

`ifdef MEM_BYTE_EN_EN
   task automatic test_byte_en();
      logic [31:0] rd; logic er; int lat;
      req_be = 4'hF;    xact(1'b1, 32'h20, 32'h11223344, rd, er, lat);
      req_be = 4'b0101; xact(1'b1, 32'h20, 32'hAABBCCDD, rd, er, lat);
      req_be = 4'hF;    xact(1'b0, 32'h20, 32'd0, rd, er, lat);
      n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_merge: got %h need 11bb33dd", rd); end
      req_be = 4'h0;    xact(1'b1, 32'h20, 32'h0, rd, er, lat);
      n_cmp++; if (er !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL be_zero_ack: got err=%b lat=%0d need 0/3", er, lat); end
      req_be = 4'hF;    xact(1'b0, 32'h20, 32'd0, rd, er, lat);
      n_cmp++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_zero: got %h need 11bb33dd", rd); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_errors();
      test_field_change();
      test_reset_mid();
      test_back_to_back();
`ifdef MEM_BYTE_EN_EN
      test_byte_en();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
